// File: rtl/lock_pkg.sv
// Shared types, defaults and width helper for the lock's code-entry path.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_LOCKED  = 2'd3
    } entry_state_t;

    localparam int DEF_CODE_LEN    = 4;
    localparam int DEF_DIGIT_W     = 4;
    localparam int DEF_TIMEOUT_CYC = 50_000_000;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_LOCK_CYC    = 100_000_000;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/code_entry_checker_if.sv
// Keypad-side bus of code_entry_checker: master is the keypad/lock, slave is the checker.
interface code_entry_checker_if #(
    parameter int CODE_LEN  = lock_pkg::DEF_CODE_LEN,
    parameter int DIGIT_W   = lock_pkg::DEF_DIGIT_W,
    parameter int MAX_TRIES = lock_pkg::DEF_MAX_TRIES
) ();
    logic                                   digit_valid;
    logic [DIGIT_W-1:0]                     digit;
    logic                                   clear;
    logic [CODE_LEN*DIGIT_W-1:0]            secret;
    logic                                   check_en;
    logic                                   check_ok;
    logic                                   busy;
    logic [lock_pkg::cnt_w(CODE_LEN)-1:0]   digit_count;
    logic [lock_pkg::cnt_w(MAX_TRIES)-1:0]  fail_count;
    logic                                   locked;

    modport master (
        output digit_valid, digit, clear, secret,
        input  check_en, check_ok, busy, digit_count, fail_count, locked
    );

    modport slave (
        input  digit_valid, digit, clear, secret,
        output check_en, check_ok, busy, digit_count, fail_count, locked
    );
endinterface

// File: rtl/code_entry_checker_digit_shift_reg.sv
// Left-shifting CODE_LEN x DIGIT_W digit register with digit count; first digit ends in the MSBs.
module digit_shift_reg
    import lock_pkg::*;
#(
    parameter int CODE_LEN = DEF_CODE_LEN,
    parameter int DIGIT_W  = DEF_DIGIT_W
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        load,
    input  logic                        clr,
    input  logic [DIGIT_W-1:0]          din,
    output logic [CODE_LEN*DIGIT_W-1:0] data,
    output logic [cnt_w(CODE_LEN)-1:0]  count
);
    logic [CODE_LEN-1:0][DIGIT_W-1:0] entry;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            entry <= '0;
            count <= '0;
        end else if (load) begin
            entry <= {entry[CODE_LEN-2:0], din};
            count <= count + 1'b1;
        end
    end

    assign data = entry;
endmodule

// File: rtl/code_entry_checker.sv
// Keypad code-entry checker: collects CODE_LEN digits and issues a one-cycle verdict strobe.
// Lockout after MAX_TRIES consecutive failures exists only when CODE_ENTRY_LOCKOUT_EN is defined.
module code_entry_checker
    import lock_pkg::*;
#(
    parameter int CODE_LEN    = DEF_CODE_LEN,
    parameter int DIGIT_W     = DEF_DIGIT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int LOCK_CYC    = DEF_LOCK_CYC
) (
    input logic                 CLK,
    input logic                 RST,
    code_entry_checker_if.slave bus
);
    localparam int CW = cnt_w(CODE_LEN);
    localparam int TW = cnt_w(TIMEOUT_CYC);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_COLLECT = ST_COLLECT;
    localparam logic [1:0] S_COMPARE = ST_COMPARE;
    localparam logic [1:0] S_LOCKED  = ST_LOCKED;

    logic [1:0]                  state;
    logic [TW-1:0]               idle_tmr;
    logic [1:0]                  vld_pipe;
    logic [1:0]                  ok_pipe;
    logic [CODE_LEN*DIGIT_W-1:0] sr_data;
    logic [CW-1:0]               sr_count;
    logic                        collect, compare, match, timeout, abort;
    logic                        sr_load, sr_clr, last_digit, lock_hit, lock_done;

    assign collect    = (state == S_COLLECT);
    assign compare    = (state == S_COMPARE);
    assign timeout    = collect && (idle_tmr == TW'(TIMEOUT_CYC - 1));
    // clear and timeout share one abort path, so a coincident pair strobes once
    assign abort      = (collect && bus.clear) || timeout;
    assign sr_load    = bus.digit_valid && !abort && (state == S_IDLE || collect);
    assign last_digit = sr_load && (sr_count == CW'(CODE_LEN - 1));
    assign sr_clr     = abort || compare;
    assign match      = (sr_data == bus.secret);

    digit_shift_reg #(
        .CODE_LEN (CODE_LEN),
        .DIGIT_W  (DIGIT_W)
    ) u_sr (
        .CLK   (CLK),
        .RST   (RST),
        .load  (sr_load),
        .clr   (sr_clr),
        .din   (bus.digit),
        .data  (sr_data),
        .count (sr_count)
    );

    // Verdict is decided on the abort/compare-exit edge and presented one edge later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            idle_tmr <= '0;
            vld_pipe <= '0;
            ok_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], abort || compare};
            ok_pipe  <= {ok_pipe[0], compare && match};
            idle_tmr <= (collect && !sr_load && !abort) ? idle_tmr + 1'b1 : '0;
            case (state)
                S_IDLE:    if (sr_load) state <= S_COLLECT;
                S_COLLECT: begin
                    if (abort)           state <= S_IDLE;
                    else if (last_digit) state <= S_COMPARE;
                end
                S_COMPARE: state <= lock_hit ? S_LOCKED : S_IDLE;
                S_LOCKED:  if (lock_done) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef CODE_ENTRY_LOCKOUT_EN
    localparam int FW = cnt_w(MAX_TRIES);
    localparam int LW = cnt_w(LOCK_CYC);

    logic [FW-1:0] fails;
    logic [LW-1:0] lock_tmr;

    assign lock_hit  = compare && !match && (fails >= FW'(MAX_TRIES - 1));
    assign lock_done = (state == S_LOCKED) && (lock_tmr == LW'(LOCK_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            fails    <= '0;
            lock_tmr <= '0;
        end else begin
            if (compare) begin
                if (match)                        fails <= '0;
                else if (fails < FW'(MAX_TRIES))  fails <= fails + 1'b1;
            end else if (lock_done) begin
                fails <= '0;
            end
            lock_tmr <= (state == S_LOCKED && !lock_done) ? lock_tmr + 1'b1 : '0;
        end
    end

    assign bus.fail_count = fails;
    assign bus.locked     = (state == S_LOCKED);
`else
    assign lock_hit       = 1'b0;
    assign lock_done      = 1'b0;
    assign bus.fail_count = '0;
    assign bus.locked     = 1'b0;
`endif

    assign bus.check_en    = vld_pipe[1];
    assign bus.check_ok    = ok_pipe[1];
    assign bus.busy        = collect || compare;
    assign bus.digit_count = sr_count;
endmodule

// File: tb/tb_code_entry_checker.sv
// Directed + randomized bench for code_entry_checker against a queue-based reference model.
module tb_code_entry_checker;
    import lock_pkg::*;

    localparam int CL = 4;
    localparam int DW = 4;
    localparam int TO = 10;
    localparam int MT = 3;
    localparam int LC = 20;
`ifdef CODE_ENTRY_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [CL*DW-1:0] secret;

    always #5 CLK = ~CLK;

    code_entry_checker_if #(.CODE_LEN(CL), .DIGIT_W(DW), .MAX_TRIES(MT)) bus ();

    code_entry_checker #(
        .CODE_LEN(CL), .DIGIT_W(DW), .TIMEOUT_CYC(TO), .MAX_TRIES(MT), .LOCK_CYC(LC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Reference model: digits held, quiet cycles, pending verdict, lockout countdown.
    int m_digits[$];
    bit m_cmp, m_pend_en, m_pend_ok, m_en, m_ok;
    int m_quiet, m_fails, m_lock;
    int n_total, n_pass, n_fail, cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit dv, input int d, input bit clr);
        bit dec_en, dec_ok;
        logic [63:0] v;
        dec_en = 1'b0;
        dec_ok = 1'b0;
        if (rst) begin
            m_digits.delete();
            m_cmp = 0; m_quiet = 0; m_fails = 0; m_lock = 0;
            m_pend_en = 0; m_pend_ok = 0; m_en = 0; m_ok = 0;
            return;
        end
        if (m_cmp) begin
            v = '0;
            foreach (m_digits[i]) v = (v << DW) | 64'(m_digits[i]);
            dec_en = 1'b1;
            dec_ok = (v == 64'(secret));
            m_digits.delete();
            m_cmp = 0;
            if (LOCKOUT) begin
                if (dec_ok) m_fails = 0;
                else begin
                    m_fails = (m_fails < MT) ? m_fails + 1 : MT;
                    if (m_fails == MT) m_lock = LC;
                end
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_digits.size() > 0) begin
            if (clr || m_quiet == TO - 1) begin
                dec_en = 1'b1;
                m_digits.delete();
                m_quiet = 0;
            end else if (dv) begin
                m_digits.push_back(d);
                m_quiet = 0;
                if (m_digits.size() == CL) m_cmp = 1;
            end else begin
                m_quiet++;
            end
        end else if (dv) begin
            m_digits.push_back(d);
            m_quiet = 0;
        end
        m_en = m_pend_en;
        m_ok = m_pend_ok;
        m_pend_en = dec_en;
        m_pend_ok = dec_ok;
    endtask

    task automatic tick(input bit rst, input bit dv, input logic [DW-1:0] d, input bit clr);
        RST = rst;
        bus.digit_valid = dv;
        bus.digit = d;
        bus.clear = clr;
        bus.secret = secret;
        @(posedge CLK);
        model_step(rst, dv, int'(d), clr);
        @(negedge CLK);
        cyc++;
        chk("check_en", 32'(bus.check_en), 32'(m_en));
        chk("check_ok", 32'(bus.check_ok), 32'(m_ok));
        chk("busy", 32'(bus.busy), 32'(m_digits.size() > 0));
        chk("digit_count", 32'(bus.digit_count), 32'(m_digits.size()));
        chk("fail_count", 32'(bus.fail_count), 32'(m_fails));
        chk("locked", 32'(bus.locked), 32'(m_lock > 0));
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic entry(input logic [CL*DW-1:0] code);
        for (int i = 0; i < CL; i++) tick(1'b0, 1'b1, code[(CL-1-i)*DW +: DW], 1'b0);
    endtask

    initial begin
        int n;
        int pos;
        logic [DW-1:0] d;
        n_total = 0; n_pass = 0; n_fail = 0; cyc = 0;
        secret = 16'h1234;
        bus.digit_valid = 1'b0; bus.digit = '0; bus.clear = 1'b0; bus.secret = secret;

        repeat (3) tick(1'b1, 1'b0, '0, 1'b0);
        chk("rst_check_en", 32'(bus.check_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_count", 32'(bus.digit_count), 0);
        chk("rst_locked", 32'(bus.locked), 0);

        // correct code: verdict two edges after the last digit
        entry(16'h1234);
        chk("cmp_busy", 32'(bus.busy), 1);
        chk("cmp_count", 32'(bus.digit_count), CL);
        idle(1);
        chk("lat1_en", 32'(bus.check_en), 0);
        chk("lat1_busy", 32'(bus.busy), 0);
        idle(1);
        chk("ok_en", 32'(bus.check_en), 1);
        chk("ok_ok", 32'(bus.check_ok), 1);
        chk("ok_fail", 32'(bus.fail_count), 0);
        idle(1);
        chk("ok_single", 32'(bus.check_en), 0);

        // wrong code then correct code
        entry(16'h1235);
        idle(2);
        chk("bad_en", 32'(bus.check_en), 1);
        chk("bad_ok", 32'(bus.check_ok), 0);
        chk("bad_fail", 32'(bus.fail_count), LOCKOUT ? 1 : 0);
        idle(1);
        entry(16'h1234);
        idle(2);
        chk("fix_ok", 32'(bus.check_ok), 1);
        chk("fix_fail", 32'(bus.fail_count), 0);

        // timeout after two digits
        idle(1);
        tick(1'b0, 1'b1, 4'd1, 1'b0);
        tick(1'b0, 1'b1, 4'd2, 1'b0);
        for (int i = 1; i <= TO; i++) begin
            idle(1);
            chk("to_wait_en", 32'(bus.check_en), 0);
        end
        chk("to_count", 32'(bus.digit_count), 0);
        idle(1);
        chk("to_en", 32'(bus.check_en), 1);
        chk("to_ok", 32'(bus.check_ok), 0);
        chk("to_fail", 32'(bus.fail_count), 0);

        // next entry may start while the previous verdict is pending
        idle(1);
        entry(16'h1234);
        idle(1);
        tick(1'b0, 1'b1, 4'd5, 1'b0);
        chk("b2b_count", 32'(bus.digit_count), 1);
        chk("b2b_en", 32'(bus.check_en), 1);
        tick(1'b0, 1'b0, '0, 1'b1);
        idle(3);

        // clear together with a digit: one abort, digit dropped
        tick(1'b0, 1'b1, 4'd1, 1'b0);
        tick(1'b0, 1'b1, 4'd2, 1'b0);
        tick(1'b0, 1'b1, 4'd3, 1'b1);
        chk("col_count", 32'(bus.digit_count), 0);
        idle(1);
        chk("col_en", 32'(bus.check_en), 1);
        chk("col_ok", 32'(bus.check_ok), 0);
        idle(1);
        chk("col_single", 32'(bus.check_en), 0);

        // clear on the timeout edge: still a single strobe
        tick(1'b0, 1'b1, 4'd7, 1'b0);
        idle(TO - 1);
        tick(1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("clrto_en", 32'(bus.check_en), 1);
        idle(1);
        chk("clrto_single", 32'(bus.check_en), 0);

        // clear in idle does nothing
        tick(1'b0, 1'b0, '0, 1'b1);
        idle(2);
        chk("idleclr_en", 32'(bus.check_en), 0);

        // reset mid-entry
        tick(1'b0, 1'b1, 4'd1, 1'b0);
        tick(1'b0, 1'b1, 4'd2, 1'b0);
        tick(1'b0, 1'b1, 4'd3, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("mrst_count", 32'(bus.digit_count), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        idle(2);
        chk("mrst_en", 32'(bus.check_en), 0);

`ifdef CODE_ENTRY_LOCKOUT_EN
        for (int t = 0; t < MT; t++) begin
            entry(16'h1111);
            idle(1);
        end
        chk("lk_locked", 32'(bus.locked), 1);
        n = 0;
        while (bus.locked && n < 2 * LC) begin
            tick(1'b0, 1'b1, 4'(n), 1'b0);
            chk("lk_count", 32'(bus.digit_count), 0);
            n++;
        end
        chk("lk_len", 32'(n), LC);
        chk("lk_fail", 32'(bus.fail_count), 0);
        entry(16'h1234);
        idle(2);
        chk("lk_pass", 32'(bus.check_ok), 1);
`else
        for (int t = 0; t < 5; t++) begin
            entry(16'h4321);
            idle(2);
            chk("nolk_en", 32'(bus.check_en), 1);
            chk("nolk_ok", 32'(bus.check_ok), 0);
            chk("nolk_locked", 32'(bus.locked), 0);
            chk("nolk_fail", 32'(bus.fail_count), 0);
        end
`endif

        // randomized traffic, digits mostly following the secret so matches occur
        for (int r = 0; r < 2; r++) begin
            idle(3);
            if (r == 1) secret = 16'($urandom);
            for (int i = 0; i < 700; i++) begin
                pos = (m_digits.size() < CL) ? m_digits.size() : 0;
                d = ($urandom_range(4, 0) != 0) ? secret[(CL-1-pos)*DW +: DW] : 4'($urandom);
                tick(($urandom_range(399, 0) == 0), ($urandom_range(2, 0) == 0), d,
                     ($urandom_range(49, 0) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
